// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32 instruction header: opcodes, funct codes, op selects, field packing.
// Range checking of immediates is compiled in with ENCODER_RANGE_CHECK_EN.
package instr_encoder_loader_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADDI = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_ADDI = 3'd4,
    OP_LUI  = 3'd5,
    OP_JAL  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_STOP,
    S_DONE
  } state_e;

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7,
    input logic [4:0] rs2,
    input logic [4:0] rs1,
    input logic [2:0] f3,
    input logic [4:0] rd,
    input logic [6:0] opc
  );
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm,
    input logic [4:0]  rs1,
    input logic [2:0]  f3,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  f3,
    input logic [6:0]  opc
  );
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_u(
    input logic [19:0] imm,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:0] imm,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

`ifdef ENCODER_RANGE_CHECK_EN
  function automatic logic imm_ok(
    input logic [2:0]  op,
    input logic [31:0] imm
  );
    logic ok;
    ok = 1'b1;
    unique case (1'b1)
      (op == OP_LW),
      (op == OP_SW):   ok = (imm[31:12] == 20'd0);
      (op == OP_ADDI): ok = (imm[31:11] == {21{imm[11]}});
      (op == OP_LUI):  ok = (imm[11:0] == 12'd0);
      (op == OP_JAL):  ok = !imm[0] && (imm[31:21] == 11'd0);
      default:         ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational RV32 field packer: (op, rd, rs1, rs2, imm) -> 32-bit word.
// Fields an op does not use are left zero; the reserved op packs to zero.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    unique case (1'b1)
      (op == OP_ADD):
        word = enc_r(F7_ADD, rs2, rs1, F3_ADD, rd, OPC_OP);
      (op == OP_SUB):
        word = enc_r(F7_SUB, rs2, rs1, F3_ADD, rd, OPC_OP);
      (op == OP_LW):
        word = enc_i(imm[11:0], rs1, F3_LW, rd, OPC_LOAD);
      (op == OP_SW):
        word = enc_s(imm[11:0], rs2, rs1, F3_SW, OPC_STORE);
      (op == OP_ADDI):
        word = enc_i(imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM);
      (op == OP_LUI):
        word = enc_u(imm[31:12], rd, OPC_LUI);
      (op == OP_JAL):
        word = enc_j(imm[20:0], rd, OPC_JAL);
      default:
        word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes symbolic instructions into instruction memory, ends with a stop word.
// Define ENCODER_RANGE_CHECK_EN to add immediate range checks and the err_imm flag.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_op,
  output logic              err_full,
`ifdef ENCODER_RANGE_CHECK_EN
  output logic              err_imm,
`endif
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  // Last slot of the window is held back for the stop word.
  localparam logic [ADDR_W-1:0] STOP_SLOT = BASE - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  state_e      state;
  logic        last_q;
  logic [31:0] enc_word;
  logic        hs;

  assign hs = in_valid && in_ready;

  instr_field_packer u_packer (
    .op   (in_op),
    .rd   (in_rd),
    .rs1  (in_rs1),
    .rs2  (in_rs2),
    .imm  (in_imm),
    .word (enc_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last_q    <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_op    <= 1'b0;
      err_full  <= 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
      err_imm   <= 1'b0;
`endif
      word_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            mem_addr <= BASE;
            word_cnt <= '0;
            err_op   <= 1'b0;
            err_full <= 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
            err_imm  <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (hs) begin
            last_q <= in_last;
            if (mem_addr == STOP_SLOT) begin
              err_full  <= 1'b1;
              state     <= S_STOP;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_wdata <= '0;
            end else if (in_op == OP_ILL) begin
              err_op <= 1'b1;
              if (in_last) begin
                state     <= S_STOP;
                in_ready  <= 1'b0;
                mem_we    <= 1'b1;
                mem_wdata <= '0;
              end
`ifdef ENCODER_RANGE_CHECK_EN
            end else if (!imm_ok(in_op, in_imm)) begin
              err_imm <= 1'b1;
              if (in_last) begin
                state     <= S_STOP;
                in_ready  <= 1'b0;
                mem_we    <= 1'b1;
                mem_wdata <= '0;
              end
`endif
            end else begin
              state     <= S_WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_wdata <= enc_word;
            end
          end
        end
        S_WRITE: begin
          mem_addr <= mem_addr + ADDR_ONE;
          word_cnt <= word_cnt + CNT_ONE;
          if (last_q) begin
            state     <= S_STOP;
            mem_we    <= 1'b1;
            mem_wdata <= '0;
          end else begin
            state    <= S_LOAD;
            mem_we   <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        S_STOP: begin
          mem_we   <= 1'b0;
          word_cnt <= word_cnt + CNT_ONE;
          state    <= S_DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: an 8-bit-address instance plus a 2-bit one.
// Covers err_imm when ENCODER_RANGE_CHECK_EN is defined.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;

  logic        ready_b, we_b, busy_b, done_b, eop_b, efull_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b;
  logic [8:0]  cnt_b;

  logic        ready_s, we_s, busy_s, done_s, eop_s, efull_s;
  logic [1:0]  addr_s;
  logic [31:0] wdata_s;
  logic [2:0]  cnt_s;

`ifdef ENCODER_RANGE_CHECK_EN
  logic eimm_b, eimm_s;
`endif

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(ready_b),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .busy(busy_b), .done(done_b),
    .err_op(eop_b), .err_full(efull_b),
`ifdef ENCODER_RANGE_CHECK_EN
    .err_imm(eimm_b),
`endif
    .word_cnt(cnt_b)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst(rst), .start(start_s),
    .in_valid(in_valid), .in_ready(ready_s),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wdata_s),
    .busy(busy_s), .done(done_s),
    .err_op(eop_s), .err_full(efull_s),
`ifdef ENCODER_RANGE_CHECK_EN
    .err_imm(eimm_s),
`endif
    .word_cnt(cnt_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [39:0] log_b[$];
  logic [33:0] log_s[$];
  int viol_b = 0;

  always @(negedge clk) begin
    if (we_b) begin
      log_b.push_back({addr_b, wdata_b});
      if (ready_b) viol_b++;
    end
    if (we_s) log_s.push_back({addr_s, wdata_s});
  end

  task automatic send(
    input bit sm, input logic [2:0] op,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] imm, input bit last,
    output bit acc, output time t
  );
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last; in_valid = 1'b1;
    acc = 1'b0; t = 0;
    for (int i = 0; i < 20; i++) begin
      if (sm ? ready_s : ready_b) begin
        @(posedge clk);
        acc = 1'b1;
        t = $time;
        break;
      end
      @(negedge clk);
    end
    if (acc) @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic do_start(input bit sm);
    if (sm) start_s = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_done(input bit sm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sm ? done_s : done_b) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_b !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_b); end
    n_cmp++;
    if (we_b !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", we_b); end
    n_cmp++;
    if ({addr_b, wdata_b} !== 40'd0) begin n_bad++; $display("FAIL reset_addr_data: got %h/%h want 0/0", addr_b, wdata_b); end
    n_cmp++;
    if ({busy_b, done_b, eop_b, efull_b} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy_b, done_b, eop_b, efull_b}); end
    n_cmp++;
    if (cnt_b !== 9'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_b); end
  endtask

  task automatic test_rtype;
    bit a1, a2, ok;
    time t;
    int base;
    base = log_b.size();
    do_start(1'b0);
    send(1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, a1, t);
    send(1'b0, 3'd1, 5'd5, 5'd6, 5'd7, 32'd0, 1'b1, a2, t);
    wait_done(1'b0, ok);
    n_cmp++;
    if ({a1, a2, ok} !== 3'b111) begin n_bad++; $display("FAIL rtype_accept_done: got %b want 111", {a1, a2, ok}); end
    n_cmp++;
    if (log_b.size() - base !== 3) begin n_bad++; $display("FAIL rtype_nwrites: got %0d want 3", log_b.size() - base); end
    n_cmp++;
    if (log_b[base] !== {8'd0, 32'h002081B3}) begin n_bad++; $display("FAIL rtype_add: got %h want 00002081b3", log_b[base]); end
    n_cmp++;
    if (log_b[base+1] !== {8'd1, 32'h407302B3}) begin n_bad++; $display("FAIL rtype_sub: got %h want 01407302b3", log_b[base+1]); end
    n_cmp++;
    if (log_b[base+2] !== {8'd2, 32'h0}) begin n_bad++; $display("FAIL rtype_stop: got %h want 0200000000", log_b[base+2]); end
    n_cmp++;
    if ({cnt_b, done_b, busy_b} !== {9'd3, 1'b1, 1'b0}) begin n_bad++; $display("FAIL rtype_status: got cnt %0d done %b busy %b want 3 1 0", cnt_b, done_b, busy_b); end
  endtask

  task automatic test_itype;
    bit a, ok;
    time t;
    int base;
    base = log_b.size();
    do_start(1'b0);
    send(1'b0, 3'd4, 5'd1, 5'd0, 5'd5, 32'hFFFF_FFFF, 1'b0, a, t);
    send(1'b0, 3'd2, 5'd4, 5'd1, 5'd0, 32'd8, 1'b0, a, t);
    send(1'b0, 3'd3, 5'd9, 5'd1, 5'd2, 32'd12, 1'b1, a, t);
    wait_done(1'b0, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL itype_done: got %b want 1", ok); end
    n_cmp++;
    if (log_b[base] !== {8'd0, 32'hFFF00093}) begin n_bad++; $display("FAIL itype_addi: got %h want 00fff00093", log_b[base]); end
    n_cmp++;
    if (log_b[base+1] !== {8'd1, 32'h0080A203}) begin n_bad++; $display("FAIL itype_lw: got %h want 010080a203", log_b[base+1]); end
    n_cmp++;
    if (log_b[base+2] !== {8'd2, 32'h0020A623}) begin n_bad++; $display("FAIL itype_sw: got %h want 020020a623", log_b[base+2]); end
    n_cmp++;
    if (log_b[base+3] !== {8'd3, 32'h0}) begin n_bad++; $display("FAIL itype_stop: got %h want 0300000000", log_b[base+3]); end
    n_cmp++;
    if (cnt_b !== 9'd4) begin n_bad++; $display("FAIL itype_cnt: got %0d want 4", cnt_b); end
  endtask

  task automatic test_utype;
    bit a, ok;
    time t;
    int base, v0;
    base = log_b.size();
    v0 = viol_b;
    do_start(1'b0);
    send(1'b0, 3'd5, 5'd5, 5'd3, 5'd0, 32'h1234_5000, 1'b0, a, t);
    send(1'b0, 3'd6, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, a, t);
    wait_done(1'b0, ok);
    n_cmp++;
    if (log_b[base] !== {8'd0, 32'h123452B7}) begin n_bad++; $display("FAIL utype_lui: got %h want 00123452b7", log_b[base]); end
    n_cmp++;
    if (log_b[base+1] !== {8'd1, 32'h008000EF}) begin n_bad++; $display("FAIL utype_jal: got %h want 01008000ef", log_b[base+1]); end
    n_cmp++;
    if (log_b[base+2] !== {8'd2, 32'h0}) begin n_bad++; $display("FAIL utype_stop: got %h want 0200000000", log_b[base+2]); end
    n_cmp++;
    if (viol_b - v0 !== 0) begin n_bad++; $display("FAIL utype_ready_in_write: got %0d want 0", viol_b - v0); end
  endtask

  task automatic test_illegal;
    bit a1, a2, a3, ok;
    time t;
    int base;
    base = log_b.size();
    do_start(1'b0);
    send(1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, a1, t);
    send(1'b0, 3'd7, 5'd8, 5'd8, 5'd8, 32'd0, 1'b0, a2, t);
    send(1'b0, 3'd1, 5'd5, 5'd6, 5'd7, 32'd0, 1'b1, a3, t);
    wait_done(1'b0, ok);
    n_cmp++;
    if ({a1, a2, a3, ok} !== 4'b1111) begin n_bad++; $display("FAIL illegal_accept: got %b want 1111", {a1, a2, a3, ok}); end
    n_cmp++;
    if (eop_b !== 1'b1) begin n_bad++; $display("FAIL illegal_err_op: got %b want 1", eop_b); end
    n_cmp++;
    if (log_b.size() - base !== 3) begin n_bad++; $display("FAIL illegal_nwrites: got %0d want 3", log_b.size() - base); end
    n_cmp++;
    if (log_b[base+1] !== {8'd1, 32'h407302B3}) begin n_bad++; $display("FAIL illegal_next_addr: got %h want 01407302b3", log_b[base+1]); end
    n_cmp++;
    if (cnt_b !== 9'd3) begin n_bad++; $display("FAIL illegal_cnt: got %0d want 3", cnt_b); end
  endtask

  task automatic test_back_to_back;
    bit a, ok;
    time t1, t2;
    do_start(1'b0);
    n_cmp++;
    if ({eop_b, efull_b, busy_b} !== 3'b001) begin n_bad++; $display("FAIL b2b_start_clear: got %b want 001", {eop_b, efull_b, busy_b}); end
    send(1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, a, t1);
    n_cmp++;
    if ({we_b, ready_b, addr_b} !== {1'b1, 1'b0, 8'd0}) begin n_bad++; $display("FAIL b2b_write_cycle: got we %b rdy %b addr %0d want 1 0 0", we_b, ready_b, addr_b); end
    send(1'b0, 3'd1, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, a, t2);
    n_cmp++;
    if ((t2 - t1) !== 64'd20) begin n_bad++; $display("FAIL b2b_spacing: got %0t want 20", t2 - t1); end
    send(1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, a, t1);
    wait_done(1'b0, ok);
    n_cmp++;
    if ({ok, cnt_b} !== {1'b1, 9'd4}) begin n_bad++; $display("FAIL b2b_cnt: got done %b cnt %0d want 1 4", ok, cnt_b); end
  endtask

  task automatic test_full;
    bit a1, a2, a3, a4, a5, ok;
    time t;
    int base;
    base = log_s.size();
    do_start(1'b1);
    send(1'b1, 3'd4, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, a1, t);
    send(1'b1, 3'd4, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, a2, t);
    send(1'b1, 3'd4, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, a3, t);
    send(1'b1, 3'd4, 5'd4, 5'd0, 5'd0, 32'd4, 1'b0, a4, t);
    send(1'b1, 3'd4, 5'd5, 5'd0, 5'd0, 32'd5, 1'b0, a5, t);
    wait_done(1'b1, ok);
    n_cmp++;
    if ({a1, a2, a3, a4, a5, ok} !== 6'b111101) begin n_bad++; $display("FAIL full_accepts: got %b want 111101", {a1, a2, a3, a4, a5, ok}); end
    n_cmp++;
    if (log_s.size() - base !== 4) begin n_bad++; $display("FAIL full_nwrites: got %0d want 4", log_s.size() - base); end
    n_cmp++;
    if (log_s[base] !== {2'd0, 32'h00100093}) begin n_bad++; $display("FAIL full_w0: got %h want 000100093", log_s[base]); end
    n_cmp++;
    if (log_s[base+2] !== {2'd2, 32'h00300193}) begin n_bad++; $display("FAIL full_w2: got %h want 200300193", log_s[base+2]); end
    n_cmp++;
    if (log_s[base+3] !== {2'd3, 32'h0}) begin n_bad++; $display("FAIL full_stop: got %h want 300000000", log_s[base+3]); end
    n_cmp++;
    if ({efull_s, done_s, cnt_s} !== {1'b1, 1'b1, 3'd4}) begin n_bad++; $display("FAIL full_status: got efull %b done %b cnt %0d want 1 1 4", efull_s, done_s, cnt_s); end
  endtask

  task automatic test_reset_mid;
    bit a;
    time t;
    int n;
    do_start(1'b0);
    send(1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, a, t);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({we_b, busy_b, ready_b, cnt_b} !== 12'd0) begin n_bad++; $display("FAIL rstmid_state: got we %b busy %b rdy %b cnt %0d want 0 0 0 0", we_b, busy_b, ready_b, cnt_b); end
    n_cmp++;
    if (addr_b !== 8'd0) begin n_bad++; $display("FAIL rstmid_addr: got %0d want 0", addr_b); end
    rst = 1'b0;
    n = log_b.size();
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({log_b.size() - n, done_b} !== {32'd0, 1'b0}) begin n_bad++; $display("FAIL rstmid_no_stop: got %0d writes done %b want 0 0", log_b.size() - n, done_b); end
  endtask

`ifdef ENCODER_RANGE_CHECK_EN
  task automatic test_range;
    bit a, ok;
    time t;
    int base;
    base = log_b.size();
    do_start(1'b0);
    send(1'b0, 3'd4, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b0, a, t);
    send(1'b0, 3'd4, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, a, t);
    wait_done(1'b0, ok);
    n_cmp++;
    if ({eimm_b, eop_b} !== 2'b10) begin n_bad++; $display("FAIL range_err_imm: got %b want 10", {eimm_b, eop_b}); end
    n_cmp++;
    if (log_b[base] !== {8'd0, 32'h7FF00093}) begin n_bad++; $display("FAIL range_ok_word: got %h want 007ff00093", log_b[base]); end
    n_cmp++;
    if (log_b[base+1] !== {8'd1, 32'h0}) begin n_bad++; $display("FAIL range_stop: got %h want 0100000000", log_b[base+1]); end
    n_cmp++;
    if (cnt_b !== 9'd2) begin n_bad++; $display("FAIL range_cnt: got %0d want 2", cnt_b); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_rtype();
    test_itype();
    test_utype();
    test_illegal();
    test_back_to_back();
    test_full();
    test_reset_mid();
`ifdef ENCODER_RANGE_CHECK_EN
    test_range();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
